simple_fixed_shift_pipe: RTL and testbench

//  Parametrised successor to the SPU even-pipe shift/rotate unit. Executes halfword/word shift, rotate and

---
 rtl/simple_fixed_shift_pipe_if.sv | 37 +++
 rtl/simple_fixed_shift_pipe.sv | 139 +++++++++++++
 tb/tb_simple_fixed_shift_pipe.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/simple_fixed_shift_pipe_if.sv
// Issue/writeback bundle for simple_fixed_shift_pipe.
//   master : issue side (op, format, rt_addr, ra, rb, imm, reg_write, branch_taken, stall) driven,
//            WB outputs and per-stage forwarding taps observed.
//   slave  : the shift pipe itself.
// Data vectors are MSB-first: bit 0 is the most significant bit, element 0 sits at bit 0.
interface simple_fixed_shift_pipe_if #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = 7
);
  logic [0:10]                      op;
  logic [2:0]                       format;
  logic [ADDR_W-1:0]                rt_addr;
  logic [0:DATA_W-1]                ra;
  logic [0:DATA_W-1]                rb;
  logic [0:17]                      imm;
  logic                             reg_write;
  logic                             branch_taken;
  logic                             stall;

  logic [0:DATA_W-1]                rt_wb;
  logic [ADDR_W-1:0]                rt_addr_wb;
  logic                             reg_write_wb;
  logic [LATENCY-1:0][0:DATA_W-1]   rt_delay;
  logic [LATENCY-1:0][ADDR_W-1:0]   rt_addr_delay;
  logic [LATENCY-1:0]               reg_write_delay;

  modport master (
    output op, format, rt_addr, ra, rb, imm, reg_write, branch_taken, stall,
    input  rt_wb, rt_addr_wb, reg_write_wb, rt_delay, rt_addr_delay, reg_write_delay
  );

  modport slave (
    input  op, format, rt_addr, ra, rb, imm, reg_write, branch_taken, stall,
    output rt_wb, rt_addr_wb, reg_write_wb, rt_delay, rt_addr_delay, reg_write_delay
  );
endinterface

// File: rtl/simple_fixed_shift_pipe.sv
// Even-pipe shift/rotate unit: halfword/word shift, rotate and rotate-and-mask (RR and RI7),
// optional quadword byte/bit shift/rotate, in a LATENCY-deep stallable pipeline.
// Ports:
//   clk    : clock, all state on the rising edge
//   reset  : synchronous active-low reset, overrides stall
//   bus    : slave modport of simple_fixed_shift_pipe_if (issue inputs, WB outputs, stage taps)
// Stage 0 takes the freshly computed result; stage LATENCY-1 drives writeback. Every output is a
// registered stage view.
module simple_fixed_shift_pipe #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = 7,
  parameter bit          EN_QUAD = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  simple_fixed_shift_pipe_if.slave bus
);

  localparam int NumH = int'(DATA_W / 16);
  localparam int NumW = int'(DATA_W / 32);

  // kind: 11 shl, 00 rot, 01 rotm (logical right by -c), 10 rotma (arith right by -c)
  function automatic logic [15:0] lane_h(input logic [1:0] kind, input logic [15:0] a,
                                         input logic [15:0] c);
    logic [15:0]        nc;
    logic [31:0]        dbl;
    logic signed [15:0] sa;
    logic [15:0]        r;
    nc  = -c;
    dbl = {a, a} << c[3:0];
    sa  = $signed(a) >>> nc[4:0];
    case (kind)
      2'b11:   r = (c[4:0] < 5'd16) ? a << c[4:0] : '0;
      2'b00:   r = dbl[31:16];
      2'b01:   r = (nc[4:0] < 5'd16) ? a >> nc[4:0] : '0;
      default: r = (nc[4:0] < 5'd16) ? $unsigned(sa) : {16{a[15]}};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_w(input logic [1:0] kind, input logic [31:0] a,
                                         input logic [31:0] c);
    logic [31:0]        nc;
    logic [63:0]        dbl;
    logic signed [31:0] sa;
    logic [31:0]        r;
    nc  = -c;
    dbl = {a, a} << c[4:0];
    sa  = $signed(a) >>> nc[5:0];
    case (kind)
      2'b11:   r = (c[5:0] < 6'd32) ? a << c[5:0] : '0;
      2'b00:   r = dbl[63:32];
      2'b01:   r = (nc[5:0] < 6'd32) ? a >> nc[5:0] : '0;
      default: r = (nc[5:0] < 6'd32) ? $unsigned(sa) : {32{a[31]}};
    endcase
    return r;
  endfunction

  logic                      is_rr, is_ri, is_q, valid;
  logic [2:0]                low;
  logic [6:0]                i7;
  logic [4:0]                qn;
  logic [2*DATA_W-1:0]       dbl;
  logic [0:DATA_W-1]         res;
  logic [0:DATA_W-1]         s0_data_d;

  logic [LATENCY-1:0][0:DATA_W-1] data_q;
  logic [LATENCY-1:0][ADDR_W-1:0] addr_q;
  logic [LATENCY-1:0]             we_q;

  always_comb begin
    low   = bus.op[8:10];
    i7    = bus.imm[11:17];
    qn    = bus.rb[27:31];
    dbl   = {bus.ra, bus.ra};
    res   = '0;
    is_rr = (bus.op[0:7] == 8'b00001011);
    is_ri = (bus.op[0:7] == 8'b00001111);
    // Quad encodings only share the RR shape for low bits 111/100/011/000.
    is_q  = EN_QUAD && (bus.op[0:7] == 8'b00111011) &&
            (low inside {3'b111, 3'b100, 3'b011, 3'b000});
    valid = !bus.branch_taken &&
            (((bus.format == 3'd0) && (is_rr || is_q)) || ((bus.format == 3'd2) && is_ri));

    if (is_q) begin
      case (low)
        3'b111: res = (qn < 5'd16) ? bus.ra << {qn, 3'b000} : '0;
        3'b100: begin
          dbl = dbl << {qn[3:0], 3'b000};
          res = dbl[2*DATA_W-1 -: DATA_W];
        end
        3'b011: res = bus.ra << qn[2:0];
        default: begin
          dbl = dbl << qn[2:0];
          res = dbl[2*DATA_W-1 -: DATA_W];
        end
      endcase
    end else if (low[2]) begin
      // op[8] set selects the halfword variant of each shift family.
      for (int i = 0; i < NumH; i++) begin
        res[16*i +: 16] = lane_h(low[1:0], bus.ra[16*i +: 16],
                                 (bus.format == 3'd2) ? {{9{i7[6]}}, i7} : bus.rb[16*i +: 16]);
      end
    end else begin
      for (int i = 0; i < NumW; i++) begin
        res[32*i +: 32] = lane_w(low[1:0], bus.ra[32*i +: 32],
                                 (bus.format == 3'd2) ? {{25{i7[6]}}, i7} : bus.rb[32*i +: 32]);
      end
    end

    s0_data_d = valid ? res : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '0;
      addr_q <= '0;
      we_q   <= '0;
    end else if (!bus.stall) begin
      data_q[0] <= s0_data_d;
      addr_q[0] <= valid ? bus.rt_addr : '0;
      we_q[0]   <= valid && bus.reg_write;
      for (int k = 1; k < int'(LATENCY); k++) begin
        data_q[k] <= data_q[k-1];
        addr_q[k] <= addr_q[k-1];
        we_q[k]   <= we_q[k-1];
      end
    end
  end

  assign bus.rt_wb           = data_q[LATENCY-1];
  assign bus.rt_addr_wb      = addr_q[LATENCY-1];
  assign bus.reg_write_wb    = we_q[LATENCY-1];
  assign bus.rt_delay        = data_q;
  assign bus.rt_addr_delay   = addr_q;
  assign bus.reg_write_delay = we_q;

endmodule

// File: tb/tb_simple_fixed_shift_pipe.sv
// Directed bench for simple_fixed_shift_pipe (DATA_W=128, LATENCY=4), plus an EN_QUAD=0 instance
// sharing the same issue stimulus.
module tb_simple_fixed_shift_pipe;
  localparam int unsigned DW  = 128;
  localparam int unsigned LAT = 4;
  localparam int unsigned AW  = 7;

  localparam logic [10:0] OpShl    = 11'b00001011011;
  localparam logic [10:0] OpShlh   = 11'b00001011111;
  localparam logic [10:0] OpRot    = 11'b00001011000;
  localparam logic [10:0] OpRothm  = 11'b00001011101;
  localparam logic [10:0] OpRotm   = 11'b00001011001;
  localparam logic [10:0] OpRotmah = 11'b00001011110;
  localparam logic [10:0] OpRotma  = 11'b00001011010;
  localparam logic [10:0] OpRoti   = 11'b00001111000;
  localparam logic [10:0] OpRothi  = 11'b00001111100;
  localparam logic [10:0] OpShlqby = 11'b00111011111;
  localparam logic [10:0] OpRotqby = 11'b00111011100;
  localparam logic [10:0] OpShlqbi = 11'b00111011011;
  localparam logic [10:0] OpRotqbi = 11'b00111011000;

  localparam logic [127:0] QData = 128'h00112233445566778899AABBCCDDEEFF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  simple_fixed_shift_pipe_if #(.DATA_W(DW), .LATENCY(LAT), .ADDR_W(AW)) bus ();
  simple_fixed_shift_pipe_if #(.DATA_W(DW), .LATENCY(LAT), .ADDR_W(AW)) bus_nq ();

  assign bus_nq.op           = bus.op;
  assign bus_nq.format       = bus.format;
  assign bus_nq.rt_addr      = bus.rt_addr;
  assign bus_nq.ra           = bus.ra;
  assign bus_nq.rb           = bus.rb;
  assign bus_nq.imm          = bus.imm;
  assign bus_nq.reg_write    = bus.reg_write;
  assign bus_nq.branch_taken = bus.branch_taken;
  assign bus_nq.stall        = bus.stall;

  simple_fixed_shift_pipe #(.DATA_W(DW), .LATENCY(LAT), .ADDR_W(AW), .EN_QUAD(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  simple_fixed_shift_pipe #(.DATA_W(DW), .LATENCY(LAT), .ADDR_W(AW), .EN_QUAD(1'b0)) dut_nq (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nq)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] w0(input logic [31:0] v);
    return {v, 96'h0};
  endfunction

  function automatic logic [127:0] h0(input logic [15:0] v);
    return {v, 112'h0};
  endfunction

  task automatic drive(input logic [10:0] op, input logic [2:0] fmt, input logic [127:0] ra,
                       input logic [127:0] rb, input logic [17:0] imm, input logic [6:0] addr,
                       input logic we, input logic bt);
    bus.op           = op;
    bus.format       = fmt;
    bus.ra           = ra;
    bus.rb           = rb;
    bus.imm          = imm;
    bus.rt_addr      = addr;
    bus.reg_write    = we;
    bus.branch_taken = bt;
  endtask

  task automatic drive_nop();
    drive(11'h0, 3'd0, '0, '0, 18'h0, 7'h0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one op, follow it with nops, check what reaches WB three edges after capture.
  task automatic run(input string tag, input logic [10:0] op, input logic [2:0] fmt,
                     input logic [127:0] ra, input logic [127:0] rb, input logic [17:0] imm,
                     input logic bt, input logic [127:0] exp, input logic exp_we);
    drive(op, fmt, ra, rb, imm, 7'h2A, 1'b1, bt);
    step();
    drive_nop();
    repeat (LAT - 1) step();
    check_eq({tag, ".data"}, bus.rt_wb, exp);
    check_eq({tag, ".we"}, bus.reg_write_wb, exp_we);
    check_eq({tag, ".addr"}, bus.rt_addr_wb, exp_we ? 7'h2A : 7'h00);
  endtask

  initial begin
    reset     = 1'b0;
    bus.stall = 1'b0;
    drive_nop();
    @(negedge clk);
    step();
    step();
    check_eq("reset.wb", bus.rt_wb, 128'h0);
    check_eq("reset.we", bus.reg_write_wb, 1'b0);
    check_eq("reset.taps", bus.rt_delay, 512'h0);
    reset = 1'b1;

    // Word / halfword shift and rotate families.
    run("shl5", OpShl, 3'd0, w0(32'h1), w0(32'd5), 18'h0, 1'b0, w0(32'h20), 1'b1);
    run("shl32", OpShl, 3'd0, w0(32'h1), w0(32'd32), 18'h0, 1'b0, 128'h0, 1'b1);
    run("shl_lanes", OpShl, 3'd0, 128'h00000001_00000001_00000001_00000001,
        128'h00000000_00000001_0000001F_00000020, 18'h0, 1'b0,
        128'h00000001_00000002_80000000_00000000, 1'b1);
    run("shlh15", OpShlh, 3'd0, h0(16'h0001), h0(16'h000F), 18'h0, 1'b0, h0(16'h8000), 1'b1);
    run("shlh16", OpShlh, 3'd0, h0(16'h0001), h0(16'h0010), 18'h0, 1'b0, 128'h0, 1'b1);
    run("rot33", OpRot, 3'd0, w0(32'h80000001), w0(32'h21), 18'h0, 1'b0, w0(32'h3), 1'b1);
    run("rotmah3", OpRotmah, 3'd0, h0(16'h8000), h0(16'hFFFD), 18'h0, 1'b0, h0(16'hF000), 1'b1);
    run("rotmah16", OpRotmah, 3'd0, h0(16'h8000), h0(16'hFFF0), 18'h0, 1'b0, h0(16'hFFFF), 1'b1);
    run("rothm3", OpRothm, 3'd0, h0(16'h8000), h0(16'hFFFD), 18'h0, 1'b0, h0(16'h1000), 1'b1);
    run("rothm16", OpRothm, 3'd0, h0(16'h8000), h0(16'hFFF0), 18'h0, 1'b0, 128'h0, 1'b1);
    run("rotm4", OpRotm, 3'd0, w0(32'h80000000), w0(32'hFFFFFFFC), 18'h0, 1'b0,
        w0(32'h08000000), 1'b1);
    run("rotma32", OpRotma, 3'd0, w0(32'h80000000), w0(32'hFFFFFFE0), 18'h0, 1'b0,
        w0(32'hFFFFFFFF), 1'b1);
    run("roti_m1", OpRoti, 3'd2, w0(32'h1), '0, 18'h0007F, 1'b0, w0(32'h80000000), 1'b1);
    run("rothi4", OpRothi, 3'd2, h0(16'h1234), '0, 18'h00004, 1'b0, h0(16'h2341), 1'b1);

    // Quadword ops; the EN_QUAD=0 copy must turn shlqby into a bubble.
    run("shlqby1", OpShlqby, 3'd0, QData, w0(32'h1), 18'h0, 1'b0,
        128'h112233445566778899AABBCCDDEEFF00, 1'b1);
    check_eq("noquad.data", bus_nq.rt_wb, 128'h0);
    check_eq("noquad.we", bus_nq.reg_write_wb, 1'b0);
    run("shlqby16", OpShlqby, 3'd0, QData, w0(32'h10), 18'h0, 1'b0, 128'h0, 1'b1);
    run("rotqby2", OpRotqby, 3'd0, QData, w0(32'h2), 18'h0, 1'b0,
        128'h2233445566778899AABBCCDDEEFF0011, 1'b1);
    run("shlqbi4", OpShlqbi, 3'd0, QData, w0(32'h4), 18'h0, 1'b0,
        128'h0112233445566778899AABBCCDDEEFF0, 1'b1);
    run("rotqbi4", OpRotqbi, 3'd0, 128'hF0000000_00000000_00000000_00000001, w0(32'h4),
        18'h0, 1'b0, 128'h1F, 1'b1);

    // Bubbles: nop, bad format, killed op, RI opcode in RR format.
    run("nop", 11'h0, 3'd0, w0(32'h1), w0(32'd5), 18'h0, 1'b0, 128'h0, 1'b0);
    run("fmt3", OpShl, 3'd3, w0(32'h1), w0(32'd5), 18'h0, 1'b0, 128'h0, 1'b0);
    run("branch", OpShl, 3'd0, w0(32'h1), w0(32'd5), 18'h0, 1'b1, 128'h0, 1'b0);
    run("ri_as_rr", OpRoti, 3'd0, w0(32'h1), w0(32'd5), 18'h0, 1'b0, 128'h0, 1'b0);

    // Stream A,B,C,D with a 2-cycle stall while C is presented.
    drive_nop();
    repeat (LAT) step();
    drive(OpShl, 3'd0, w0(32'h1), w0(32'd1), 18'h0, 7'd1, 1'b1, 1'b0);
    step();
    drive(OpShl, 3'd0, w0(32'h1), w0(32'd2), 18'h0, 7'd2, 1'b1, 1'b0);
    step();
    drive(OpShl, 3'd0, w0(32'h1), w0(32'd3), 18'h0, 7'd3, 1'b1, 1'b0);
    bus.stall = 1'b1;
    step();
    step();
    check_eq("stall.addr", bus.rt_addr_delay, {7'd0, 7'd0, 7'd1, 7'd2});
    check_eq("stall.we", bus.reg_write_delay, 4'b0011);
    check_eq("stall.data", bus.rt_delay, {128'h0, 128'h0, w0(32'h2), w0(32'h4)});
    bus.stall = 1'b0;
    step();
    drive(OpShl, 3'd0, w0(32'h1), w0(32'd4), 18'h0, 7'd4, 1'b1, 1'b0);
    step();
    drive_nop();
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("stream%0d.addr", k), bus.rt_addr_wb, 7'(k));
      check_eq($sformatf("stream%0d.we", k), bus.reg_write_wb, 1'b1);
      check_eq($sformatf("stream%0d.data", k), bus.rt_wb, w0(32'h1 << k));
      step();
    end

    // Reset with stall asserted and a full pipe.
    drive(OpShl, 3'd0, w0(32'h1), w0(32'd7), 18'h0, 7'd5, 1'b1, 1'b0);
    repeat (LAT) step();
    check_eq("full.we", bus.reg_write_delay, 4'b1111);
    bus.stall = 1'b1;
    reset     = 1'b0;
    step();
    check_eq("rst_stall.data", bus.rt_delay, 512'h0);
    check_eq("rst_stall.addr", bus.rt_addr_delay, 28'h0);
    check_eq("rst_stall.we", bus.reg_write_delay, 4'b0000);
    check_eq("rst_stall.wb", bus.rt_wb, 128'h0);
    reset     = 1'b1;
    bus.stall = 1'b0;
    drive_nop();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
